tr_track_ramp: RTL and testbench
================================

TR_TRACK_RAMP -- requirements
Module: tr_track_ramp

Interface
REQ-001 Parameter X_W, default 12: ADC sample width; x, x0, dx1 and dx2 are all unsigned X_W bits.
REQ-002 Parameter N_W, default 17: step-period width, in clk cycles.
REQ-003 Parameter N_MAX, default 20000: start/stop period, the slowest rate.
REQ-004 Parameter N_SLOW, default 5000: target period in the slow band.
REQ-005 Parameter N_FAST, default 500: target period in the fast band.
REQ-006 Parameter RAMP_STEP, default 500: period change applied per emitted step.
REQ-007 Parameter PULSE_W, default 4: drv_step high width, in clk cycles; legal only when PULSE_W < N_FAST <= N_SLOW <= N_MAX < 2^N_W.
REQ-008 clk  in  1  single system clock; every flop is on its rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 data_valid  in  1  one-cycle strobe marking a new ADC sample on x.
REQ-011 tr_mode_enable  in  1  tracking permit.
REQ-012 x  in  X_W  ADC sample.
REQ-013 x0  in  X_W  setpoint.
REQ-014 dx1  in  X_W  deadband half-width.
REQ-015 dx2  in  X_W  fast-band threshold, with dx2 >= dx1.
REQ-016 drv_step  out  1  step pulse to the motor driver.
REQ-017 drv_dir  out  1  direction: 1 when x > x0.
REQ-018 drv_enable_SM  out  1  stepper driver enable.
REQ-019 N  out  N_W  currently applied step period.

Function
REQ-020 On data_valid=1, the block SHALL register e = x - x0 as a signed X_W+1 value and |e| as X_W bits; the decision uses these registered values on the following cycle.
REQ-021 Band classification SHALL be: |e| <= dx1 -> STOP; dx1 < |e| <= dx2 -> SLOW (target N_SLOW); |e| > dx2 -> FAST (target N_FAST).
REQ-022 tr_mode_enable=0 SHALL force the band to STOP, regardless of e.
REQ-023 States SHALL be IDLE, ACCEL, RUN, DECEL.
REQ-024 IDLE: N = N_MAX, no step pulses; a non-STOP band SHALL latch drv_dir = (e > 0) and move to ACCEL.
REQ-025 Period counter: cnt counts 0..N-1 and wraps; drv_step SHALL be high exactly while cnt < PULSE_W.
REQ-026 N SHALL only be updated at a cnt wrap, never mid-period.
REQ-027 ACCEL: at each wrap, N <= max(N - RAMP_STEP, target); when N equals the target, go to RUN.
REQ-028 RUN: a faster target SHALL return to ACCEL; a slower target SHALL go to DECEL, which ramps N up and clamps at the target.
REQ-029 Band STOP, or a sign of e opposite to drv_dir, SHALL cause DECEL toward N_MAX.
REQ-030 On reaching N_MAX, DECEL SHALL complete the current period and then enter IDLE.
REQ-031 drv_dir SHALL change only in IDLE, so a reversal always passes through N_MAX and IDLE.
REQ-032 drv_enable_SM SHALL be 1 in every state except IDLE.
REQ-033 drv_enable_SM SHALL fall on the cycle IDLE is entered.
REQ-034 In all arithmetic, N SHALL never leave the range [N_FAST, N_MAX]; additions are N_W+1 bits wide, then clamped.
REQ-035 When data_valid coincides with a cnt wrap, the ramp step SHALL use the band in force before that sample.

Reset
REQ-036 While rst=1, drv_step, drv_dir and drv_enable_SM SHALL be 0, N SHALL be N_MAX, cnt SHALL be 0, the state SHALL be IDLE, and the registered error SHALL be 0.
REQ-037 Reset asserted mid-pulse or mid-ramp SHALL take effect immediately, with no completion of the current pulse.

Structure
REQ-038 Package tr_pkg SHALL hold the state enum, the band enum, and default parameter constants.
REQ-039 Sub-module tr_step_gen SHALL contain the period counter and pulse generator, with inputs N and run and outputs drv_step and wrap.
REQ-040 tr_track_ramp SHALL hold the error path and the FSM.

Verification
REQ-041 Fast ramp: x0=10, dx1=150, dx2=1500, x=2000 -> ACCEL; N = 20000, 19500, ... down to 500 after 39 steps, then RUN with drv_dir=1.
REQ-042 Deadband: x=100 (|e|=90) -> the FSM stays in IDLE, no drv_step pulses, drv_enable_SM=0.
REQ-043 Slow band: x=1000 -> N ramps 20000 down to 5000 in 30 steps and then holds at 5000.
REQ-044 Reversal: in RUN at N=500 with drv_dir=1, apply x=0 (e=-10, beyond dx1 for dx1=5) -> DECEL to N_MAX, IDLE for 1 cycle, drv_dir=0, then ACCEL.
REQ-045 Enable drop: tr_mode_enable falls during RUN -> DECEL to N_MAX -> IDLE, with drv_enable_SM falling only on IDLE entry.
REQ-046 Reset mid-pulse: rst raised while drv_step=1 -> drv_step=0 in the same cycle, N=20000, state IDLE.

Source files
------------

// File: rtl/tr_pkg.sv
// Shared types and default constants for the tracking stepper ramp controller.
package tr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_RUN,
        ST_DECEL
    } tr_state_t;

    typedef enum logic [1:0] {
        BAND_STOP,
        BAND_SLOW,
        BAND_FAST
    } tr_band_t;

    localparam int TR_X_W       = 12;
    localparam int TR_N_W       = 17;
    localparam int TR_N_MAX     = 20000;
    localparam int TR_N_SLOW    = 5000;
    localparam int TR_N_FAST    = 500;
    localparam int TR_RAMP_STEP = 500;
    localparam int TR_PULSE_W   = 4;

endpackage

// File: rtl/tr_step_gen.sv
// Step period counter: counts 0..N-1 while running and emits a PULSE_W-wide step
// at the start of every period, plus a wrap strobe on the last cycle of the period.
module tr_step_gen #(
    parameter int N_W     = 17,
    parameter int PULSE_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [N_W-1:0] N,
    output logic           drv_step,
    output logic           wrap
);

    logic [N_W-1:0] cnt;
    logic [N_W-1:0] cnt_last;

    assign cnt_last = N - N_W'(1);

    // Counter parks at 0 while stopped so a new run starts with a full pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || cnt == cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + N_W'(1);
        end
    end

    assign wrap     = run && (cnt == cnt_last);
    assign drv_step = run && (cnt < N_W'(PULSE_W));

endmodule

// File: rtl/tr_track_ramp.sv
// Tracking stepper controller: registers the ADC error, classifies it into a speed band
// and ramps the step period between N_MAX and the band target, one change per period.
module tr_track_ramp
    import tr_pkg::*;
#(
    parameter int X_W       = TR_X_W,
    parameter int N_W       = TR_N_W,
    parameter int N_MAX     = TR_N_MAX,
    parameter int N_SLOW    = TR_N_SLOW,
    parameter int N_FAST    = TR_N_FAST,
    parameter int RAMP_STEP = TR_RAMP_STEP,
    parameter int PULSE_W   = TR_PULSE_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           data_valid,
    input  logic           tr_mode_enable,
    input  logic [X_W-1:0] x,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] dx1,
    input  logic [X_W-1:0] dx2,
    output logic           drv_step,
    output logic           drv_dir,
    output logic           drv_enable_SM,
    output logic [N_W-1:0] N
);

    localparam logic [N_W:0] NMAX_E  = (N_W+1)'(N_MAX);
    localparam logic [N_W:0] NSLOW_E = (N_W+1)'(N_SLOW);
    localparam logic [N_W:0] NFAST_E = (N_W+1)'(N_FAST);
    localparam logic [N_W:0] RAMP_E  = (N_W+1)'(RAMP_STEP);

    tr_state_t             state, state_next;
    tr_band_t              band;
    logic signed [X_W:0]   e_now, e_reg;
    logic [X_W-1:0]        abs_now, abs_reg;
    logic                  e_pos;
    logic                  want_stop;
    logic                  dir_q, dir_next;
    logic [N_W-1:0]        n_q, n_next;
    logic [N_W:0]          n_ext, target_e, n_dn, n_up, n_ramp;
    logic                  run, wrap;

    assign e_now   = $signed({1'b0, x}) - $signed({1'b0, x0});
    assign abs_now = e_now[X_W] ? X_W'(-e_now) : e_now[X_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_reg   <= '0;
            abs_reg <= '0;
        end else if (data_valid) begin
            e_reg   <= e_now;
            abs_reg <= abs_now;
        end
    end

    always_comb begin
        band = BAND_STOP;
        if (tr_mode_enable && abs_reg > dx1) begin
            band = (abs_reg > dx2) ? BAND_FAST : BAND_SLOW;
        end
    end

    assign e_pos     = !e_reg[X_W] && (e_reg != '0);
    assign want_stop = (band == BAND_STOP) || (e_pos != dir_q);

    always_comb begin
        target_e = NMAX_E;
        if (!want_stop) begin
            target_e = (band == BAND_FAST) ? NFAST_E : NSLOW_E;
        end
    end

    // One ramp step toward the target, clamped so the target is never overshot.
    assign n_ext  = {1'b0, n_q};
    assign n_dn   = (n_ext > target_e + RAMP_E) ? n_ext - RAMP_E : target_e;
    assign n_up   = (n_ext + RAMP_E < target_e) ? n_ext + RAMP_E : target_e;
    assign n_ramp = (n_ext > target_e) ? n_dn : n_up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            n_q   <= N_W'(N_MAX);
            dir_q <= 1'b0;
        end else begin
            state <= state_next;
            n_q   <= n_next;
            dir_q <= dir_next;
        end
    end

    // Outside IDLE every decision waits for a period wrap, so N never changes mid-period.
    always_comb begin
        state_next = state;
        n_next     = n_q;
        dir_next   = dir_q;
        case (state)
            ST_IDLE: begin
                n_next = N_W'(N_MAX);
                if (band != BAND_STOP) begin
                    dir_next   = e_pos;
                    state_next = ST_ACCEL;
                end
            end
            default: begin
                if (wrap) begin
                    if (want_stop && n_ext == NMAX_E) begin
                        state_next = ST_IDLE;
                    end else begin
                        n_next = n_ramp[N_W-1:0];
                        if (want_stop) begin
                            state_next = ST_DECEL;
                        end else if (n_ramp == target_e) begin
                            state_next = ST_RUN;
                        end else if (n_ramp > target_e) begin
                            state_next = ST_ACCEL;
                        end else begin
                            state_next = ST_DECEL;
                        end
                    end
                end
            end
        endcase
    end

    assign run           = (state != ST_IDLE);
    assign drv_enable_SM = run;
    assign drv_dir       = dir_q;
    assign N             = n_q;

    tr_step_gen #(
        .N_W     (N_W),
        .PULSE_W (PULSE_W)
    ) u_step_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .N        (n_q),
        .drv_step (drv_step),
        .wrap     (wrap)
    );

endmodule

// File: tb/tb_tr_track_ramp.sv
// Bench for tr_track_ramp with periods scaled by 1/100 so full ramps stay short;
// a cycle-level behavioural model is compared on every cycle, plus directed scenarios.
module tb_tr_track_ramp;

    localparam int X_W       = 12;
    localparam int N_W       = 10;
    localparam int N_MAX     = 200;
    localparam int N_SLOW    = 50;
    localparam int N_FAST    = 5;
    localparam int RAMP_STEP = 5;
    localparam int PULSE_W   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           data_valid = 1'b0;
    logic           tr_mode_enable = 1'b0;
    logic [X_W-1:0] x = '0;
    logic [X_W-1:0] x0 = '0;
    logic [X_W-1:0] dx1 = '0;
    logic [X_W-1:0] dx2 = '0;
    logic           drv_step;
    logic           drv_dir;
    logic           drv_enable_SM;
    logic [N_W-1:0] N;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    tr_track_ramp #(
        .X_W       (X_W),
        .N_W       (N_W),
        .N_MAX     (N_MAX),
        .N_SLOW    (N_SLOW),
        .N_FAST    (N_FAST),
        .RAMP_STEP (RAMP_STEP),
        .PULSE_W   (PULSE_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_valid     (data_valid),
        .tr_mode_enable (tr_mode_enable),
        .x              (x),
        .x0             (x0),
        .dx1            (dx1),
        .dx2            (dx2),
        .drv_step       (drv_step),
        .drv_dir        (drv_dir),
        .drv_enable_SM  (drv_enable_SM),
        .N              (N)
    );

    always #5 clk = ~clk;

    // Model state: is the motor moving, which way, current period and position within it.
    int m_err = 0;
    int m_period = N_MAX;
    int m_phase = 0;
    bit m_moving = 1'b0;
    bit m_dir = 1'b0;
    int m_mag;
    int m_tgt;
    bit m_stop_band;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_err    = 0;
            m_period = N_MAX;
            m_phase  = 0;
            m_moving = 1'b0;
            m_dir    = 1'b0;
        end else begin
            m_mag       = (m_err < 0) ? -m_err : m_err;
            m_stop_band = !tr_mode_enable || (m_mag <= int'(dx1));
            m_tgt       = m_stop_band ? N_MAX : ((m_mag > int'(dx2)) ? N_FAST : N_SLOW);
            if (!m_moving) begin
                if (!m_stop_band) begin
                    m_moving = 1'b1;
                    m_dir    = (m_err > 0);
                    m_phase  = 0;
                end
            end else if (m_phase == m_period - 1) begin
                m_phase = 0;
                if (m_stop_band || ((m_err > 0) != m_dir)) m_tgt = N_MAX;
                if (m_tgt == N_MAX && m_period == N_MAX) begin
                    m_moving = 1'b0;
                end else if (m_period > m_tgt) begin
                    m_period = (m_period - RAMP_STEP < m_tgt) ? m_tgt : m_period - RAMP_STEP;
                end else begin
                    m_period = (m_period + RAMP_STEP > m_tgt) ? m_tgt : m_period + RAMP_STEP;
                end
            end else begin
                m_phase = m_phase + 1;
            end
            if (data_valid) m_err = int'(x) - int'(x0);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (compare_on && !rst) begin
            checkOutput("model_step", int'(drv_step), int'(m_moving && m_phase < PULSE_W));
            checkOutput("model_dir", int'(drv_dir), int'(m_dir));
            checkOutput("model_enable", int'(drv_enable_SM), int'(m_moving));
            checkOutput("model_N", int'(N), m_period);
        end
    end

    task automatic applyStimulus(input bit en, input int xv, input int x0v,
                                 input int d1, input int d2, input bit strobe);
        @(negedge clk);
        #1;
        tr_mode_enable = en;
        x              = X_W'(xv);
        x0             = X_W'(x0v);
        dx1            = X_W'(d1);
        dx2            = X_W'(d2);
        data_valid     = strobe;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic waitPeriod(input int target, input int budget, output int changes);
        int prev;
        int n;
        prev    = int'(N);
        changes = 0;
        n       = 0;
        while (int'(N) != target && n < budget) begin
            @(negedge clk);
            if (int'(N) != prev) changes++;
            prev = int'(N);
            n++;
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (drv_enable_SM && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int changes;
        int pulses;
        int idle_cycles;
        int n;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("reset_step", int'(drv_step), 0);
        checkOutput("reset_dir", int'(drv_dir), 0);
        checkOutput("reset_enable", int'(drv_enable_SM), 0);
        checkOutput("reset_N", int'(N), 200);
        #1 rst = 1'b0;
        compare_on = 1'b1;

        $display("[TB] deadband");
        applyStimulus(1'b1, 100, 10, 150, 1500, 1'b1);
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            if (drv_step) pulses++;
        end
        checkOutput("deadband_pulses", pulses, 0);
        checkOutput("deadband_enable", int'(drv_enable_SM), 0);

        $display("[TB] fast ramp");
        applyStimulus(1'b1, 2000, 10, 150, 1500, 1'b1);
        waitPeriod(5, 6000, changes);
        checkOutput("fast_N", int'(N), 5);
        checkOutput("fast_steps", changes, 39);
        checkOutput("fast_dir", int'(drv_dir), 1);
        repeat (40) @(negedge clk);
        checkOutput("fast_hold_N", int'(N), 5);

        $display("[TB] back to idle, then slow band");
        applyStimulus(1'b1, 100, 10, 150, 1500, 1'b1);
        waitIdle(6000);
        checkOutput("stop_enable", int'(drv_enable_SM), 0);
        checkOutput("stop_N", int'(N), 200);
        applyStimulus(1'b1, 1000, 10, 150, 1500, 1'b1);
        waitPeriod(50, 6000, changes);
        checkOutput("slow_N", int'(N), 50);
        checkOutput("slow_steps", changes, 30);
        repeat (300) @(negedge clk);
        checkOutput("slow_hold_N", int'(N), 50);

        $display("[TB] reversal");
        applyStimulus(1'b1, 2000, 10, 150, 1500, 1'b1);
        waitPeriod(5, 2000, changes);
        checkOutput("rev_pre_N", int'(N), 5);
        applyStimulus(1'b1, 0, 10, 5, 1500, 1'b1);
        waitIdle(6000);
        checkOutput("rev_idle_N", int'(N), 200);
        checkOutput("rev_idle_dir", int'(drv_dir), 1);
        idle_cycles = 0;
        while (!drv_enable_SM && idle_cycles < 10) begin
            @(negedge clk);
            idle_cycles++;
        end
        checkOutput("rev_idle_cycles", idle_cycles, 1);
        checkOutput("rev_new_dir", int'(drv_dir), 0);

        $display("[TB] enable drop");
        waitPeriod(50, 6000, changes);
        checkOutput("drop_run_N", int'(N), 50);
        applyStimulus(1'b0, 0, 10, 5, 1500, 1'b0);
        checkOutput("drop_enable_held", int'(drv_enable_SM), 1);
        waitIdle(6000);
        checkOutput("drop_enable", int'(drv_enable_SM), 0);
        checkOutput("drop_N", int'(N), 200);
        repeat (20) @(negedge clk);
        checkOutput("drop_stays_idle", int'(drv_enable_SM), 0);

        $display("[TB] reset mid-pulse");
        applyStimulus(1'b1, 2000, 10, 150, 1500, 1'b1);
        n = 0;
        while (!drv_step && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pre_reset_step", int'(drv_step), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_step", int'(drv_step), 0);
        checkOutput("midrst_N", int'(N), 200);
        checkOutput("midrst_enable", int'(drv_enable_SM), 0);
        checkOutput("midrst_dir", int'(drv_dir), 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        $display("[TB] randomized tracking");
        for (int seg = 0; seg < 40; seg++) begin
            int d1;
            int d2;
            int xz;
            bit en;
            d1 = $urandom_range(0, 300);
            d2 = d1 + $urandom_range(0, 1500);
            xz = $urandom_range(0, 4095);
            en = ($urandom_range(0, 7) != 0);
            applyStimulus(en, $urandom_range(0, 4095), xz, d1, d2, 1'b1);
            repeat ($urandom_range(50, 600)) begin
                if ($urandom_range(0, 63) == 0)
                    applyStimulus(en, $urandom_range(0, 4095), xz, d1, d2, 1'b1);
                else
                    @(negedge clk);
            end
        end

        compare_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
